pingpong_ctrl: RTL and testbench
================================

PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 512: bits per ping-pong half; must equal the buffer's MAX_COUNT.
REQ-002 SHALL have parameter SWAP_CYCLES, default 2: cycles `switch` is held high per swap; legal range is 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that leaves IDLE and begins filling.
REQ-006 SHALL have port stop, input, 1 bit: one-cycle pulse requesting a return to IDLE at the next frame boundary.
REQ-007 SHALL have port fir_done, input, 1 bit: one-cycle pulse from the convolution engine marking the end of its current frame.
REQ-008 SHALL have port switch, output, 1 bit: drives the buffer; high pauses the buffer counter, and its rising edge swaps halves.
REQ-009 SHALL have port in_ready, output, 1 bit: high when the current cycle's bit_in is being captured.
REQ-010 SHALL have port fir_start, output, 1 bit: one-cycle pulse telling the engine that a full frame is readable.
REQ-011 SHALL have port active_buf, output, 1 bit: mirror of the buffer's active-half select.
REQ-012 SHALL have port frame_cnt, output, 16 bits: count of completed swaps; wraps modulo 2^16.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag; a swap was due while the engine was still busy.

Function
REQ-014 SHALL implement an FSM with states IDLE, FILL, SWAP, and STALL (STALL only per REQ-025).
REQ-015 SHALL drive switch=1 in IDLE, SWAP and STALL, and switch=0 in FILL; in_ready SHALL equal ~switch.
REQ-016 SHALL keep bit_idx (clog2(FRAME_LEN) bits), incremented every FILL cycle, so it stays lockstep with the buffer counter.
REQ-017 SHALL transition IDLE->FILL on start; bit_idx SHALL not reset, so alignment with the buffer counter is kept.
REQ-018 SHALL, in FILL with bit_idx==FRAME_LEN-1: wrap bit_idx to 0 and go to SWAP next cycle.
REQ-019 SHALL hold SWAP for exactly SWAP_CYCLES cycles.
REQ-020 SHALL, on SWAP entry: toggle active_buf, increment frame_cnt, and set fir_busy.
REQ-021 SHALL pulse fir_start on the last SWAP cycle, except for the first swap after reset, which carries no valid frame.
REQ-022 SHALL, on SWAP exit: go to IDLE if stop is latched (then clear the latch), else go to FILL.
REQ-023 SHALL clear fir_busy on fir_done; fir_done arriving while fir_busy=0 is ignored.
REQ-024 SHALL, when fir_done and a SWAP entry coincide: clear first, then set, so fir_busy=1 and no overrun.
REQ-025 SHALL, in the no-stall build at SWAP entry with fir_busy=1 (after the clear of REQ-024): set overrun and swap anyway.
REQ-026 SHALL ignore start outside IDLE; a stop during IDLE SHALL have no effect.
REQ-027 SHALL give start priority if start and stop arrive in the same IDLE cycle; the stop is discarded.

Reset
REQ-028 SHALL, while rst_n=0, set: state=IDLE, bit_idx=0, active_buf=0, frame_cnt=0, overrun=0, fir_busy=0, stop latch=0, first-swap flag=1.
REQ-029 SHALL, while rst_n=0, drive outputs switch=1, in_ready=0, fir_start=0.
REQ-030 SHALL abort any state when reset asserts mid-frame; the buffer is reset by the same rst_n, so both realign at 0.

Configuration
REQ-031 SHALL support macro PINGPONG_CTRL_STALL_EN; when defined, a SWAP entry with fir_busy=1 goes to STALL instead.
REQ-032 SHALL, in STALL: hold switch=1, keep active_buf/frame_cnt unchanged, and on fir_done go to SWAP next cycle; overrun is never set.
REQ-033 SHALL, without PINGPONG_CTRL_STALL_EN: omit STALL entirely and use the overrun behaviour of REQ-025.

Structure
REQ-034 SHALL place the state enum typedef and the default FRAME_LEN/SWAP_CYCLES constants in shared package pingpong_pkg.
REQ-035 SHALL have one sub-module, frame_sequencer, holding bit_idx and the FILL terminal-count compare; everything else is flat.

Verification
REQ-036 SHALL cover: reset, start, FRAME_LEN=512 -> switch low 512 cycles, high 2; frame_cnt=1; active_buf=1; no fir_start.
REQ-037 SHALL cover: second frame, fir_done 100 cycles after fir_start -> fir_start pulses at end of swap 2; overrun=0; frame_cnt=2.
REQ-038 SHALL cover: fir_done withheld across swap 3, no-stall build -> overrun=1 (sticky until reset); active_buf toggles anyway.
REQ-039 SHALL cover: fir_done withheld, STALL_EN build -> switch stays high until fir_done+1; then SWAP; overrun=0.
REQ-040 SHALL cover: stop at bit_idx=200 -> FILL completes to 511, SWAP, then IDLE; start resumes with bit_idx=0 aligned.
REQ-041 SHALL cover: rst_n low at bit_idx=300 -> all outputs at reset values within the same cycle (asynchronous); restart realigns.

Source files
------------

// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared state encoding and default sizing for the ping-pong controller.
// STALL exists only when PINGPONG_CTRL_STALL_EN is defined.
package pingpong_pkg;

    localparam int FRAME_LEN_DEF   = 512;
    localparam int SWAP_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SWAP
`ifdef PINGPONG_CTRL_STALL_EN
        , ST_STALL
`endif
    } pp_state_e;

endpackage

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - bit index within the current half, kept lockstep with the buffer counter.
module frame_sequencer
    import pingpong_pkg::*;
#(
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill,
    output logic [IDX_W-1:0] bit_idx,
    output logic             last_bit
);

    logic [IDX_W-1:0] bit_idx_q;
    logic [IDX_W-1:0] bit_idx_d;

    always_comb begin
        last_bit  = fill && (bit_idx_q == IDX_W'(FRAME_LEN - 1));
        bit_idx_d = bit_idx_q;
        if (fill) begin
            bit_idx_d = last_bit ? '0 : bit_idx_q + 1'b1;
        end
    end

    // Never cleared outside reset: the buffer counter only pauses, so we only pause too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx_q <= '0;
        end else begin
            bit_idx_q <= bit_idx_d;
        end
    end

    assign bit_idx = bit_idx_q;

endmodule

// File: rtl/pingpong_ctrl.sv
// rtl/pingpong_ctrl.sv - ping-pong buffer controller: fill, swap and engine hand-off sequencing.
// Define PINGPONG_CTRL_STALL_EN to stall on a busy engine instead of flagging overrun.
module pingpong_ctrl
    import pingpong_pkg::*;
#(
    parameter int FRAME_LEN   = FRAME_LEN_DEF,
    parameter int SWAP_CYCLES = SWAP_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        fir_done,
    output logic        switch,
    output logic        in_ready,
    output logic        fir_start,
    output logic        active_buf,
    output logic [15:0] frame_cnt,
    output logic        overrun
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int SC_W  = $clog2(SWAP_CYCLES + 1);

    pp_state_e   state_q, state_d;
    logic [SC_W-1:0] swap_cnt_q, swap_cnt_d;
    logic        active_buf_q, active_buf_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        overrun_q, overrun_d;
    logic        fir_busy_q, fir_busy_d;
    logic        stop_q, stop_d;
    logic        first_q, first_d;

    logic             last_bit;
    logic [IDX_W-1:0] bit_idx;
    logic             busy_clr;
    logic             swap_entry;
    logic             swap_last;

    frame_sequencer #(
        .FRAME_LEN (FRAME_LEN)
    ) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .fill     (state_q == ST_FILL),
        .bit_idx  (bit_idx),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d      = state_q;
        swap_cnt_d   = swap_cnt_q;
        active_buf_d = active_buf_q;
        frame_cnt_d  = frame_cnt_q;
        overrun_d    = overrun_q;
        first_d      = first_q;
        swap_entry   = 1'b0;
        // A done arriving on the same edge as a swap entry is consumed before the new set.
        busy_clr     = fir_busy_q & ~fir_done;
        fir_busy_d   = busy_clr;
        swap_last    = (state_q == ST_SWAP) && (swap_cnt_q == SC_W'(SWAP_CYCLES - 1));
        stop_d       = stop_q | (stop & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (last_bit) begin
`ifdef PINGPONG_CTRL_STALL_EN
                    if (busy_clr) begin
                        state_d = ST_STALL;
                    end else begin
                        swap_entry = 1'b1;
                    end
`else
                    swap_entry = 1'b1;
`endif
                end
            end
            ST_SWAP: begin
                swap_cnt_d = swap_cnt_q + 1'b1;
                if (swap_last) begin
                    first_d = 1'b0;
                    if (stop_q || stop) begin
                        state_d = ST_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
`ifdef PINGPONG_CTRL_STALL_EN
            ST_STALL: begin
                if (fir_done) begin
                    swap_entry = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The first swap after reset hands over no frame, so the engine is not marked busy.
        if (swap_entry) begin
            state_d      = ST_SWAP;
            swap_cnt_d   = '0;
            active_buf_d = ~active_buf_q;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            fir_busy_d   = busy_clr | ~first_q;
`ifndef PINGPONG_CTRL_STALL_EN
            overrun_d    = overrun_q | busy_clr;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            swap_cnt_q   <= '0;
            active_buf_q <= 1'b0;
            frame_cnt_q  <= '0;
            overrun_q    <= 1'b0;
            fir_busy_q   <= 1'b0;
            stop_q       <= 1'b0;
            first_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            swap_cnt_q   <= swap_cnt_d;
            active_buf_q <= active_buf_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
            fir_busy_q   <= fir_busy_d;
            stop_q       <= stop_d;
            first_q      <= first_d;
        end
    end

    assign switch     = (state_q != ST_FILL);
    assign in_ready   = ~switch;
    assign fir_start  = swap_last & ~first_q;
    assign active_buf = active_buf_q;
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb/tb_pingpong_ctrl.sv - directed self-checking bench for pingpong_ctrl (both build options).
module tb_pingpong_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        fir_done;
    logic        switch;
    logic        in_ready;
    logic        fir_start;
    logic        active_buf;
    logic [15:0] frame_cnt;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int fs_cnt   = 0;
    int fs_pos   = 0;
    int hi_run   = 0;
    int n;
    int fs_before;

    pingpong_ctrl #(
        .FRAME_LEN   (512),
        .SWAP_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .fir_done   (fir_done),
        .switch     (switch),
        .in_ready   (in_ready),
        .fir_start  (fir_start),
        .active_buf (active_buf),
        .frame_cnt  (frame_cnt),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        hi_run <= switch ? hi_run + 1 : 0;
        if (fir_start) begin
            fs_cnt <= fs_cnt + 1;
            fs_pos <= switch ? hi_run + 1 : 0;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_switch(input logic val, input int max, output int cycles);
        cycles = 0;
        while (switch !== val && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        fir_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_switch", switch, 1);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_fir_start", fir_start, 0);
        check_eq("rst_active_buf", active_buf, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_switch", switch, 1);

        // Frame 1: first swap carries no frame.
        pulse_start();
        check_eq("fill_in_ready", in_ready, 1);
        wait_switch(1'b1, 2000, n);
        check_eq("f1_low_cycles", n, 512);
        check_eq("f1_frame_cnt", frame_cnt, 1);
        check_eq("f1_active_buf", active_buf, 1);
        check_eq("swap_in_ready", in_ready, 0);
        wait_switch(1'b0, 50, n);
        check_eq("f1_high_cycles", n, 2);
        check_eq("f1_no_fir_start", fs_cnt, 0);

        // Frame 2: engine finishes ~100 cycles after fir_start.
        wait_switch(1'b1, 2000, n);
        check_eq("f2_low_cycles", n, 512);
        check_eq("f2_frame_cnt", frame_cnt, 2);
        check_eq("f2_active_buf", active_buf, 0);
        wait_switch(1'b0, 50, n);
        check_eq("f2_high_cycles", n, 2);
        check_eq("f2_fir_start_cnt", fs_cnt, 1);
        check_eq("f2_fir_start_pos", fs_pos, 2);
        repeat (98) @(negedge clk);
        fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;

        // Frame 3: engine idle at the swap, no overrun; engine then withholds done.
        wait_switch(1'b1, 2000, n);
        check_eq("f3_frame_cnt", frame_cnt, 3);
        check_eq("f3_overrun", overrun, 0);
        wait_switch(1'b0, 50, n);
        check_eq("f3_fir_start_cnt", fs_cnt, 2);

        // Frame 4: swap due while engine still busy.
        wait_switch(1'b1, 2000, n);
        check_eq("f4_low_cycles", n, 512);
`ifdef PINGPONG_CTRL_STALL_EN
        repeat (20) @(negedge clk);
        check_eq("stall_switch", switch, 1);
        check_eq("stall_frame_cnt", frame_cnt, 3);
        check_eq("stall_active_buf", active_buf, 1);
        fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;
        check_eq("stall_exit_frame_cnt", frame_cnt, 4);
        wait_switch(1'b0, 50, n);
        check_eq("stall_swap_cycles", n, 2);
        check_eq("f4_overrun", overrun, 0);
`else
        check_eq("f4_overrun", overrun, 1);
        wait_switch(1'b0, 50, n);
        check_eq("f4_high_cycles", n, 2);
`endif
        check_eq("f4_frame_cnt", frame_cnt, 4);
        check_eq("f4_active_buf", active_buf, 0);
        check_eq("f4_fir_start_cnt", fs_cnt, 3);

        // Frame 5: done at bit 50, stop at bit 200, return to IDLE after the swap.
        repeat (50) @(negedge clk);
        fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;
        repeat (149) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_switch(1'b1, 2000, n);
        check_eq("stop_low_remaining", n, 311);
        repeat (10) @(negedge clk);
        check_eq("stop_idle_switch", switch, 1);
        check_eq("stop_frame_cnt", frame_cnt, 5);
        check_eq("stop_active_buf", active_buf, 1);
        check_eq("stop_fir_start_cnt", fs_cnt, 4);
`ifdef PINGPONG_CTRL_STALL_EN
        check_eq("stop_overrun", overrun, 0);
`else
        check_eq("sticky_overrun", overrun, 1);
`endif
        fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;

        // Start and stop together: start wins, stop discarded.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        wait_switch(1'b1, 2000, n);
        check_eq("resume_low_cycles", n, 512);
        wait_switch(1'b0, 50, n);
        check_eq("resume_high_cycles", n, 2);
        fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;
        wait_switch(1'b1, 2000, n);
        check_eq("no_stop_low_cycles", n, 511);
        check_eq("f7_frame_cnt", frame_cnt, 7);
        wait_switch(1'b0, 50, n);

        // Asynchronous reset mid-frame at bit 300.
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_switch", switch, 1);
        check_eq("arst_in_ready", in_ready, 0);
        check_eq("arst_fir_start", fir_start, 0);
        check_eq("arst_frame_cnt", frame_cnt, 0);
        check_eq("arst_active_buf", active_buf, 0);
        check_eq("arst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fs_before = fs_cnt;
        pulse_start();
        wait_switch(1'b1, 2000, n);
        check_eq("realign_low_cycles", n, 512);
        check_eq("realign_frame_cnt", frame_cnt, 1);
        wait_switch(1'b0, 50, n);
        check_eq("realign_high_cycles", n, 2);
        check_eq("realign_no_fir_start", fs_cnt - fs_before, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
